// File: rtl/axi4_rd_rr_scheduler.sv
// Shares one AXI4 read port (AR+R) among NUM requesters: round-robin AR arbitration
// with a per-requester outstanding-burst limit, and R beats routed back by the ARID prefix.
module axi4_rd_rr_scheduler #(
  parameter int unsigned NUM     = 4,
  parameter int unsigned IDSIZE  = 4,
  parameter int unsigned ASIZE   = 8,
  parameter int unsigned LSIZE   = 8,
  parameter int unsigned DSIZE   = 8,
  parameter int unsigned MAX_OUT = 8
) (
  input  logic                              clock,
  input  logic                              rst,
  input  logic [NUM-1:0]                    s_arvalid,
  output logic [NUM-1:0]                    s_arready,
  input  logic [NUM*IDSIZE-1:0]             s_arid,
  input  logic [NUM*ASIZE-1:0]              s_araddr,
  input  logic [NUM*LSIZE-1:0]              s_arlen,
  output logic [NUM-1:0]                    s_rvalid,
  input  logic [NUM-1:0]                    s_rready,
  output logic [IDSIZE-1:0]                 s_rid,
  output logic [DSIZE-1:0]                  s_rdata,
  output logic                              s_rlast,
  output logic                              m_arvalid,
  input  logic                              m_arready,
  output logic [IDSIZE+$clog2(NUM)-1:0]     m_arid,
  output logic [ASIZE-1:0]                  m_araddr,
  output logic [LSIZE-1:0]                  m_arlen,
  input  logic                              m_rvalid,
  output logic                              m_rready,
  input  logic [IDSIZE+$clog2(NUM)-1:0]     m_rid,
  input  logic [DSIZE-1:0]                  m_rdata,
  input  logic                              m_rlast,
  output logic                              err_route
);

  localparam int unsigned SW = $clog2(NUM);
  localparam int unsigned MW = IDSIZE + SW;
  localparam int unsigned CW = 8;

  typedef enum logic {IDLE, ISSUE} state_t;

  state_t            state, state_n;
  logic [SW-1:0]     ptr;
  logic [SW-1:0]     gnt;
  logic [CW-1:0]     cnt [NUM];
  logic [NUM-1:0]    elig;
  logic              found;
  logic [SW-1:0]     win;
  logic [SW-1:0]     cand;
  logic              load;
  logic              issue_done;
  logic [SW-1:0]     sel;
  logic              last_done;
  logic [NUM-1:0]    inc;
  logic [NUM-1:0]    dec;
  logic [IDSIZE-1:0] arid_a  [NUM];
  logic [ASIZE-1:0]  araddr_a[NUM];
  logic [LSIZE-1:0]  arlen_a [NUM];

  // Unpack per-requester AR fields and eligibility
  always_comb begin
    for (int unsigned k = 0; k < NUM; k++) begin
      arid_a[k]   = s_arid[k*IDSIZE +: IDSIZE];
      araddr_a[k] = s_araddr[k*ASIZE +: ASIZE];
      arlen_a[k]  = s_arlen[k*LSIZE +: LSIZE];
      elig[k]     = s_arvalid[k] && (cnt[k] < CW'(MAX_OUT));
    end
  end

  // Round-robin search starting one past the last granted requester
  always_comb begin
    found = 1'b0;
    win   = '0;
    cand  = '0;
    for (int unsigned i = 1; i <= NUM; i++) begin
      cand = ptr + SW'(i);
      if (!found && elig[cand]) begin
        found = 1'b1;
        win   = cand;
      end
    end
  end

  always_comb begin
    state_n    = state;
    s_arready  = '0;
    load       = 1'b0;
    issue_done = 1'b0;
    case (state)
      IDLE: begin
        if (found && !rst) begin
          s_arready[win] = 1'b1;
          load           = 1'b1;
          state_n        = ISSUE;
        end
      end
      ISSUE: begin
        if (m_arready) begin
          issue_done = 1'b1;
          state_n    = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // R path: pure routing by the requester prefix of RID
  always_comb begin
    sel           = m_rid[MW-1:IDSIZE];
    s_rvalid      = '0;
    s_rvalid[sel] = m_rvalid;
    m_rready      = s_rready[sel];
    s_rid         = m_rid[IDSIZE-1:0];
    s_rdata       = m_rdata;
    s_rlast       = m_rlast;
    last_done     = m_rvalid && m_rready && m_rlast;
  end

  always_comb begin
    for (int unsigned k = 0; k < NUM; k++) begin
      inc[k] = issue_done && (gnt == SW'(k));
      dec[k] = last_done && (sel == SW'(k)) && (cnt[k] != '0);
    end
  end

  always_ff @(posedge clock) begin
    if (rst) begin
      state     <= IDLE;
      ptr       <= SW'(NUM - 1);
      gnt       <= '0;
      m_arvalid <= 1'b0;
      m_arid    <= '0;
      m_araddr  <= '0;
      m_arlen   <= '0;
      err_route <= 1'b0;
      for (int unsigned k = 0; k < NUM; k++) cnt[k] <= '0;
    end else begin
      state <= state_n;
      if (load) begin
        m_arvalid <= 1'b1;
        m_arid    <= {win, arid_a[win]};
        m_araddr  <= araddr_a[win];
        m_arlen   <= arlen_a[win];
        gnt       <= win;
      end
      if (issue_done) begin
        m_arvalid <= 1'b0;
        ptr       <= gnt;
      end
      // A last beat with nothing outstanding is a routing error, never an underflow
      if (last_done && (cnt[sel] == '0)) err_route <= 1'b1;
      for (int unsigned k = 0; k < NUM; k++) begin
        if (inc[k] && !dec[k])      cnt[k] <= cnt[k] + CW'(1);
        else if (!inc[k] && dec[k]) cnt[k] <= cnt[k] - CW'(1);
      end
    end
  end

endmodule

// File: tb/tb_axi4_rd_rr_scheduler.sv
// Randomized bench for axi4_rd_rr_scheduler against a transaction-level model of
// grants, outstanding counts and R routing.
module tb_axi4_rd_rr_scheduler;

  localparam int unsigned NUM     = 4;
  localparam int unsigned IDSIZE  = 4;
  localparam int unsigned ASIZE   = 8;
  localparam int unsigned LSIZE   = 8;
  localparam int unsigned DSIZE   = 8;
  localparam int unsigned MAX_OUT = 8;
  localparam int unsigned SW      = 2;
  localparam int unsigned MW      = IDSIZE + SW;

  logic                  clock = 1'b0;
  logic                  rst;
  logic [NUM-1:0]        s_arvalid, s_arready, s_rvalid, s_rready;
  logic [NUM*IDSIZE-1:0] s_arid;
  logic [NUM*ASIZE-1:0]  s_araddr;
  logic [NUM*LSIZE-1:0]  s_arlen;
  logic [IDSIZE-1:0]     s_rid;
  logic [DSIZE-1:0]      s_rdata, m_rdata;
  logic                  s_rlast, m_arvalid, m_arready, m_rvalid, m_rready, m_rlast, err_route;
  logic [MW-1:0]         m_arid, m_rid;
  logic [ASIZE-1:0]      m_araddr;
  logic [LSIZE-1:0]      m_arlen;

  axi4_rd_rr_scheduler #(
    .NUM(NUM), .IDSIZE(IDSIZE), .ASIZE(ASIZE), .LSIZE(LSIZE), .DSIZE(DSIZE), .MAX_OUT(MAX_OUT)
  ) dut (
    .clock(clock), .rst(rst),
    .s_arvalid(s_arvalid), .s_arready(s_arready), .s_arid(s_arid), .s_araddr(s_araddr),
    .s_arlen(s_arlen), .s_rvalid(s_rvalid), .s_rready(s_rready), .s_rid(s_rid),
    .s_rdata(s_rdata), .s_rlast(s_rlast), .m_arvalid(m_arvalid), .m_arready(m_arready),
    .m_arid(m_arid), .m_araddr(m_araddr), .m_arlen(m_arlen), .m_rvalid(m_rvalid),
    .m_rready(m_rready), .m_rid(m_rid), .m_rdata(m_rdata), .m_rlast(m_rlast),
    .err_route(err_route)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Model: one AR may be held at the downstream port; last_gnt drives the rotation
  bit            busy;
  int            hold_idx;
  int            last_gnt;
  logic [MW-1:0] hold_arid;
  logic [ASIZE-1:0] hold_addr;
  logic [LSIZE-1:0] hold_len;
  int            outst [NUM];
  bit            err;

  task automatic model_reset();
    busy      = 0;
    hold_idx  = 0;
    last_gnt  = NUM - 1;
    hold_arid = '0;
    hold_addr = '0;
    hold_len  = '0;
    err       = 0;
    for (int k = 0; k < NUM; k++) outst[k] = 0;
  endtask

  task automatic drive(input int arv_pct, input logic [NUM-1:0] mask, input int ardy_pct,
                       input int rv_pct, input int rlast_pct, input int rrdy_pct);
    int idx;
    int live [$];
    for (int k = 0; k < NUM; k++) begin
      s_arvalid[k] = mask[k] && ($urandom_range(99) < arv_pct);
      s_rready[k]  = $urandom_range(99) < rrdy_pct;
    end
    s_arid    = (NUM*IDSIZE)'($urandom);
    s_araddr  = (NUM*ASIZE)'($urandom);
    s_arlen   = (NUM*LSIZE)'($urandom);
    m_arready = $urandom_range(99) < ardy_pct;
    m_rvalid  = $urandom_range(99) < rv_pct;
    m_rlast   = $urandom_range(99) < rlast_pct;
    m_rdata   = DSIZE'($urandom);
    for (int k = 0; k < NUM; k++) if (outst[k] > 0) live.push_back(k);
    if (live.size() > 0 && $urandom_range(99) < 85) idx = live[$urandom_range(live.size() - 1)];
    else idx = $urandom_range(NUM - 1);
    m_rid = MW'(idx * (1 << IDSIZE) + $urandom_range((1 << IDSIZE) - 1));
  endtask

  // One clock: check combinational outputs, advance the model, check registered outputs
  task automatic step(input logic r);
    int win;
    int sel;
    logic [NUM-1:0] exp_ardy;
    logic [NUM-1:0] exp_rv;
    rst = r;
    #1;
    win = -1;
    exp_ardy = '0;
    if (!r && !busy)
      for (int j = 1; j <= NUM; j++) begin
        int c;
        c = (last_gnt + j) % NUM;
        if (win < 0 && s_arvalid[c] && outst[c] < MAX_OUT) win = c;
      end
    if (win >= 0) exp_ardy[win] = 1'b1;
    sel = int'(m_rid) / (1 << IDSIZE);
    exp_rv = '0;
    if (m_rvalid) exp_rv[sel] = 1'b1;
    check_eq("s_arready", 64'(s_arready), 64'(exp_ardy));
    check_eq("s_rvalid",  64'(s_rvalid),  64'(exp_rv));
    check_eq("m_rready",  64'(m_rready),  64'(s_rready[sel]));
    check_eq("s_rid",     64'(s_rid),     64'(int'(m_rid) % (1 << IDSIZE)));
    check_eq("s_rdata",   64'(s_rdata),   64'(m_rdata));
    check_eq("s_rlast",   64'(s_rlast),   64'(m_rlast));
    if (r) model_reset();
    else begin
      if (m_rvalid && s_rready[sel] && m_rlast) begin
        if (outst[sel] == 0) err = 1;
        else outst[sel]--;
      end
      if (busy) begin
        if (m_arready) begin
          busy = 0;
          last_gnt = hold_idx;
          outst[hold_idx]++;
        end
      end else if (win >= 0) begin
        busy      = 1;
        hold_idx  = win;
        hold_arid = MW'(win * (1 << IDSIZE) + int'((s_arid >> (win * IDSIZE)) % (1 << IDSIZE)));
        hold_addr = ASIZE'(s_araddr >> (win * ASIZE));
        hold_len  = LSIZE'(s_arlen >> (win * LSIZE));
      end
    end
    @(posedge clock);
    #1;
    check_eq("m_arvalid", 64'(m_arvalid), 64'(busy));
    check_eq("m_arid",    64'(m_arid),    64'(hold_arid));
    check_eq("m_araddr",  64'(m_araddr),  64'(hold_addr));
    check_eq("m_arlen",   64'(m_arlen),   64'(hold_len));
    check_eq("err_route", 64'(err_route), 64'(err));
  endtask

  initial begin
    rst = 1'b1;
    model_reset();
    drive(100, '1, 50, 0, 0, 50);
    s_arvalid = '1;
    // Reset held with all requesters asking
    for (int c = 0; c < 3; c++) begin
      @(negedge clock);
      drive(100, '1, 50, 30, 50, 50);
      step(1'b1);
    end
    // General traffic with occasional mid-run reset
    for (int c = 0; c < 700; c++) begin
      @(negedge clock);
      drive(70, '1, 60, 50, 40, 70);
      step($urandom_range(99) < 1);
    end
    // Requester 0 alone, no R returns: drives it to the outstanding limit
    @(negedge clock);
    drive(0, '0, 100, 0, 0, 100);
    step(1'b1);
    for (int c = 0; c < 40; c++) begin
      @(negedge clock);
      drive(100, 4'b0001, 100, 0, 0, 100);
      step(1'b0);
    end
    check_eq("limit_cnt0", 64'(outst[0]), 64'(MAX_OUT));
    for (int c = 0; c < 200; c++) begin
      @(negedge clock);
      drive(100, 4'b0001, 100, 40, 50, 80);
      step(1'b0);
    end
    // Heavy AR backpressure, all requesters, frequent bursts
    for (int c = 0; c < 700; c++) begin
      @(negedge clock);
      drive(90, '1, 15, 70, 60, 50);
      step(1'b0);
    end
    // Unroutable last beats: error must stick
    for (int c = 0; c < 100; c++) begin
      @(negedge clock);
      drive(40, '1, 80, 80, 80, 90);
      step(1'b0);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
